// File: rtl/data_mem_access.sv
// MEM-stage load/store responder for a word-wide, variable-latency data memory.
// Handles byte-lane steering, load alignment/extension, stalls and bus timeouts.
module data_mem_access #(
  parameter int TIMEOUT  = 255,
  parameter int TO_WIDTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        M_MemRead,
  input  logic        M_MemWrite,
  input  logic        M_MemByte,
  input  logic        M_MemHalf,
  input  logic        M_MemSignExt,
  input  logic [31:0] M_Addr,
  input  logic [31:0] M_WriteData,
  output logic        M_Stall,
  output logic [31:0] M_ReadData,
  output logic        M_AddrErr,
  output logic        M_BusErr,
  output logic [29:0] DataMem_Addr,
  output logic [31:0] DataMem_Out,
  output logic [3:0]  DataMem_WE,
  output logic        DataMem_Read,
  input  logic [31:0] DataMem_In,
  input  logic        DataMem_Ready
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RD,
    WAIT_WR,
    DONE
  } state_t;

  localparam logic [TO_WIDTH-1:0] ToLast =
    TO_WIDTH'(TIMEOUT - 1);
  localparam bit ToEnable = (TIMEOUT != 0);

  state_t state;
  state_t stateNext;

  logic [29:0]         addrQ;
  logic [1:0]          offQ;
  logic                byteQ;
  logic                halfQ;
  logic                signQ;
  logic [3:0]          weQ;
  logic [31:0]         outQ;
  logic [TO_WIDTH-1:0] cnt;
  logic [31:0]         readDataQ;
  logic                busErrQ;

  logic        request;
  logic        isByte;
  logic        isHalf;
  logic        aligned;
  logic [3:0]  storeWe;
  logic [31:0] storeOut;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;
  logic [31:0] loadVal;
  logic        timedOut;
  logic        accept;
  logic        abort;

  assign request = M_MemRead | M_MemWrite;
  assign isByte  = M_MemByte;
  assign isHalf  = M_MemHalf & ~M_MemByte;
  assign aligned = isByte
                 | (isHalf & ~M_Addr[0])
                 | (~isByte & ~isHalf
                    & (M_Addr[1:0] == 2'b00));
  assign timedOut = ToEnable && (cnt == ToLast);

  // Big-endian lane enables and replicated store data
  always_comb begin
    storeWe  = 4'b1111;
    storeOut = M_WriteData;
    unique case (1'b1)
      isByte: begin
        storeWe  = 4'b1000 >> M_Addr[1:0];
        storeOut = {4{M_WriteData[7:0]}};
      end
      isHalf: begin
        storeWe  = M_Addr[1] ? 4'b0011 : 4'b1100;
        storeOut = {2{M_WriteData[15:0]}};
      end
      default: begin
        storeWe  = 4'b1111;
        storeOut = M_WriteData;
      end
    endcase
  end

  // Lane select and extension of the returning load word
  always_comb begin
    loadByte = 8'h00;
    unique case (offQ)
      2'd0: loadByte = DataMem_In[31:24];
      2'd1: loadByte = DataMem_In[23:16];
      2'd2: loadByte = DataMem_In[15:8];
      2'd3: loadByte = DataMem_In[7:0];
      default: loadByte = 8'h00;
    endcase
    loadHalf = offQ[1] ? DataMem_In[15:0]
                       : DataMem_In[31:16];
    loadVal = DataMem_In;
    unique case (1'b1)
      byteQ:
        loadVal = {{24{signQ & loadByte[7]}},
                   loadByte};
      halfQ:
        loadVal = {{16{signQ & loadHalf[15]}},
                   loadHalf};
      default: loadVal = DataMem_In;
    endcase
  end

  // Next state, stall, strobes and error pulses
  always_comb begin
    stateNext    = state;
    M_Stall      = 1'b0;
    M_AddrErr    = 1'b0;
    DataMem_Read = 1'b0;
    DataMem_WE   = 4'b0000;
    accept       = 1'b0;
    abort        = 1'b0;
    unique case (state)
      IDLE: begin
        if (request) begin
          if (!aligned) begin
            M_AddrErr = 1'b1;
          end else begin
            M_Stall   = 1'b1;
            accept    = 1'b1;
            stateNext = M_MemRead ? WAIT_RD
                                  : WAIT_WR;
          end
        end
      end
      WAIT_RD: begin
        M_Stall      = 1'b1;
        DataMem_Read = 1'b1;
        if (DataMem_Ready) begin
          stateNext = DONE;
        end else if (timedOut) begin
          abort     = 1'b1;
          stateNext = DONE;
        end
      end
      WAIT_WR: begin
        M_Stall    = 1'b1;
        DataMem_WE = weQ;
        if (DataMem_Ready) begin
          stateNext = DONE;
        end else if (timedOut) begin
          abort     = 1'b1;
          stateNext = DONE;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // State, latched request, wait counter and load result
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      addrQ     <= '0;
      offQ      <= '0;
      byteQ     <= 1'b0;
      halfQ     <= 1'b0;
      signQ     <= 1'b0;
      weQ       <= '0;
      outQ      <= '0;
      cnt       <= '0;
      readDataQ <= '0;
      busErrQ   <= 1'b0;
    end else begin
      state   <= stateNext;
      busErrQ <= abort;
      if (accept) begin
        addrQ <= M_Addr[31:2];
        offQ  <= M_Addr[1:0];
        byteQ <= isByte;
        halfQ <= isHalf;
        signQ <= M_MemSignExt;
        weQ   <= M_MemRead ? 4'b0000 : storeWe;
        outQ  <= storeOut;
        cnt   <= '0;
      end else if ((state == WAIT_RD
                    || state == WAIT_WR)
                   && !DataMem_Ready
                   && !timedOut) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
      if (state == WAIT_RD && DataMem_Ready) begin
        readDataQ <= loadVal;
      end else if (abort) begin
        readDataQ <= '0;
      end
    end
  end

  assign M_ReadData   = readDataQ;
  assign M_BusErr     = busErrQ;
  assign DataMem_Addr = addrQ;
  assign DataMem_Out  = outQ;

endmodule

// File: tb/tb_data_mem_access.sv
// Scoreboard bench for data_mem_access.
// Stimulus pushes expected events; a negedge monitor pops and compares.
module tb_data_mem_access;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        M_MemRead = 1'b0;
  logic        M_MemWrite = 1'b0;
  logic        M_MemByte = 1'b0;
  logic        M_MemHalf = 1'b0;
  logic        M_MemSignExt = 1'b0;
  logic [31:0] M_Addr = '0;
  logic [31:0] M_WriteData = '0;
  logic        M_Stall;
  logic [31:0] M_ReadData;
  logic        M_AddrErr;
  logic        M_BusErr;
  logic [29:0] DataMem_Addr;
  logic [31:0] DataMem_Out;
  logic [3:0]  DataMem_WE;
  logic        DataMem_Read;
  logic [31:0] DataMem_In = '0;
  logic        DataMem_Ready = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          isErr;
    logic [31:0] rdata;
    bit          busErr;
    int          stall;
    int          rdCyc;
    int          weCyc;
    logic [3:0]  we;
    logic [31:0] out;
    logic [29:0] addr;
  } exp_t;

  exp_t expQ[$];

  data_mem_access #(
    .TIMEOUT (4),
    .TO_WIDTH(8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .M_MemRead    (M_MemRead),
    .M_MemWrite   (M_MemWrite),
    .M_MemByte    (M_MemByte),
    .M_MemHalf    (M_MemHalf),
    .M_MemSignExt (M_MemSignExt),
    .M_Addr       (M_Addr),
    .M_WriteData  (M_WriteData),
    .M_Stall      (M_Stall),
    .M_ReadData   (M_ReadData),
    .M_AddrErr    (M_AddrErr),
    .M_BusErr     (M_BusErr),
    .DataMem_Addr (DataMem_Addr),
    .DataMem_Out  (DataMem_Out),
    .DataMem_WE   (DataMem_WE),
    .DataMem_Read (DataMem_Read),
    .DataMem_In   (DataMem_In),
    .DataMem_Ready(DataMem_Ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // monitor state
  int   stallCnt = 0;
  int   rdCnt = 0;
  int   weCnt = 0;
  logic [3:0]  seenWe = '0;
  logic [31:0] seenOut = '0;
  logic [29:0] seenAddr = '0;
  bit   prevStall = 0;

  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      stallCnt = 0; rdCnt = 0; weCnt = 0;
      seenWe = '0; seenOut = '0; seenAddr = '0;
      prevStall = 0;
    end else begin
      stallCnt += int'(M_Stall);
      rdCnt    += int'(DataMem_Read);
      weCnt    += int'(|DataMem_WE);
      if (DataMem_Read || |DataMem_WE)
        seenAddr = DataMem_Addr;
      if (|DataMem_WE) begin
        seenWe  = DataMem_WE;
        seenOut = DataMem_Out;
      end
      if (M_AddrErr || (prevStall && !M_Stall)) begin
        if (expQ.size() == 0) begin
          chk("unexpected_event", 32'd1, 32'd0);
        end else begin
          e = expQ.pop_front();
          chk("event_kind", {31'd0, M_AddrErr},
              {31'd0, e.isErr});
          chk("stall_cycles", stallCnt, e.stall);
          chk("read_cycles", rdCnt, e.rdCyc);
          chk("we_cycles", weCnt, e.weCyc);
          if (!e.isErr) begin
            chk("read_data", M_ReadData, e.rdata);
            chk("bus_err", {31'd0, M_BusErr},
                {31'd0, e.busErr});
            chk("done_strobes",
                {27'd0, DataMem_WE, DataMem_Read}, 0);
            chk("bus_addr", {2'd0, seenAddr},
                {2'd0, e.addr});
            if (e.weCyc > 0) begin
              chk("write_en", {28'd0, seenWe},
                  {28'd0, e.we});
              chk("write_out", seenOut, e.out);
            end
          end
        end
        stallCnt = 0; rdCnt = 0; weCnt = 0;
        seenWe = '0; seenOut = '0;
      end else if (M_BusErr) begin
        chk("bus_err_outside_done", 32'd1, 32'd0);
      end
      prevStall = M_Stall;
    end
  end

  function automatic exp_t mk(
      input bit isErr, input logic [31:0] rdata,
      input bit busErr, input int stall,
      input int rdCyc, input int weCyc,
      input logic [3:0] we, input logic [31:0] out,
      input logic [29:0] addr);
    exp_t e;
    e.isErr = isErr; e.rdata = rdata;
    e.busErr = busErr; e.stall = stall;
    e.rdCyc = rdCyc; e.weCyc = weCyc;
    e.we = we; e.out = out; e.addr = addr;
    return e;
  endfunction

  task automatic clearReq();
    M_MemRead = 0; M_MemWrite = 0;
    M_MemByte = 0; M_MemHalf = 0;
    M_MemSignExt = 0; DataMem_Ready = 0;
  endtask

  // readyAfter: WAIT cycle in which Ready is raised (-1 = never)
  task automatic access(input bit rd, input bit wr,
                        input bit by, input bit hf,
                        input bit sx,
                        input logic [31:0] addr,
                        input logic [31:0] wd,
                        input logic [31:0] memIn,
                        input int readyAfter);
    bit done;
    @(posedge clock); #1;
    M_MemRead = rd; M_MemWrite = wr;
    M_MemByte = by; M_MemHalf = hf;
    M_MemSignExt = sx; M_Addr = addr;
    M_WriteData = wd; DataMem_In = memIn;
    DataMem_Ready = 0;
    #1;
    if (M_Stall) begin
      done = 0;
      for (int n = 1; n <= 50; n++) begin
        @(posedge clock); #1;
        if (!M_Stall) begin
          done = 1;
          break;
        end
        DataMem_Ready = (n == readyAfter);
      end
      if (!done) chk("access_timeout", 32'd1, 32'd0);
    end else begin
      @(posedge clock); #1;
    end
    clearReq();
    @(posedge clock); #1;
  endtask

  initial begin
    clearReq();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_stall", {31'd0, M_Stall}, 0);
    chk("rst_rdata", M_ReadData, 0);
    chk("rst_addr", {2'd0, DataMem_Addr}, 0);
    chk("rst_out", DataMem_Out, 0);
    chk("rst_strobes",
        {27'd0, DataMem_WE, DataMem_Read}, 0);
    chk("rst_errs", {30'd0, M_AddrErr, M_BusErr}, 0);
    reset = 0;

    expQ.push_back(mk(0, 32'hDEADBEEF, 0, 4, 3, 0,
                      4'h0, 0, 30'h40));
    access(1, 0, 0, 0, 0, 32'h100, 0,
           32'hDEADBEEF, 3);
    expQ.push_back(mk(0, 32'hFFFFFF8F, 0, 2, 1, 0,
                      4'h0, 0, 30'h40));
    access(1, 0, 1, 0, 1, 32'h103, 0,
           32'h1122338F, 1);
    expQ.push_back(mk(0, 32'h0000008F, 0, 2, 1, 0,
                      4'h0, 0, 30'h40));
    access(1, 0, 1, 0, 0, 32'h103, 0,
           32'h1122338F, 1);
    expQ.push_back(mk(0, 32'hFFFFF00D, 0, 2, 1, 0,
                      4'h0, 0, 30'h40));
    access(1, 0, 0, 1, 1, 32'h102, 0,
           32'h0000F00D, 1);

    expQ.push_back(mk(0, 32'hFFFFF00D, 0, 3, 0, 2,
                      4'b0100, 32'hABABABAB, 30'h80));
    access(0, 1, 1, 0, 0, 32'h201, 32'h000000AB,
           0, 2);
    expQ.push_back(mk(0, 32'hFFFFF00D, 0, 2, 0, 1,
                      4'b0011, 32'h12341234, 30'h80));
    access(0, 1, 0, 1, 0, 32'h202, 32'h00001234,
           0, 1);
    expQ.push_back(mk(0, 32'hFFFFF00D, 0, 2, 0, 1,
                      4'b1111, 32'hCAFEF00D, 30'h81));
    access(0, 1, 0, 0, 0, 32'h204, 32'hCAFEF00D,
           0, 1);

    expQ.push_back(mk(1, 0, 0, 0, 0, 0, 4'h0, 0, 0));
    access(1, 0, 0, 0, 0, 32'h102, 0, 0, 1);
    expQ.push_back(mk(1, 0, 0, 0, 0, 0, 4'h0, 0, 0));
    access(1, 0, 0, 1, 1, 32'h101, 0, 0, 1);

    expQ.push_back(mk(0, 32'h0, 1, 5, 4, 0,
                      4'h0, 0, 30'h40));
    access(1, 0, 0, 0, 0, 32'h100, 0,
           32'h12345678, -1);
    expQ.push_back(mk(0, 32'h55AA55AA, 0, 5, 4, 0,
                      4'h0, 0, 30'h42));
    access(1, 0, 0, 0, 0, 32'h108, 0,
           32'h55AA55AA, 4);
    expQ.push_back(mk(0, 32'h00008001, 0, 2, 1, 0,
                      4'h0, 0, 30'h40));
    access(1, 0, 0, 1, 0, 32'h100, 0,
           32'h80017FFF, 1);

    // reset while a store is waiting
    @(posedge clock); #1;
    M_MemWrite = 1; M_Addr = 32'h204;
    M_WriteData = 32'h1;
    repeat (2) @(posedge clock);
    #1;
    chk("wr_pending_we", {28'd0, DataMem_WE},
        32'hF);
    reset = 1;
    clearReq(); M_MemWrite = 0;
    @(posedge clock); #1;
    reset = 0;
    chk("rstw_we", {28'd0, DataMem_WE}, 0);
    chk("rstw_stall", {31'd0, M_Stall}, 0);
    chk("rstw_read", {31'd0, DataMem_Read}, 0);
    chk("rstw_rdata", M_ReadData, 0);
    @(posedge clock); #1;
    chk("rstw_idle_stall", {31'd0, M_Stall}, 0);

    expQ.push_back(mk(0, 32'h0BADCAFE, 0, 2, 1, 0,
                      4'h0, 0, 30'hC0));
    access(1, 1, 0, 0, 0, 32'h300, 32'hFFFFFFFF,
           32'h0BADCAFE, 1);

    repeat (3) @(posedge clock);
    #1;
    chk("queue_drained", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
